// File: rtl/dmem_arbiter_if.sv
// Data-memory port bundle between the CPU MEM stage, the serial debugger and the data RAM.
// The arbiter uses the slave modport; the environment uses the master modport.
interface dmem_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wd;
  logic [WIDTH-1:0] cpu_rd;
  logic             cpu_stall;

  logic             dbg_req;
  logic             dbg_we;
  logic [WIDTH-1:0] dbg_addr;
  logic [WIDTH-1:0] dbg_wd;
  logic             dbg_gnt;
  logic             dbg_rvalid;
  logic [WIDTH-1:0] dbg_rdata;

  logic             ram_we;
  logic [WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0] ram_wd;
  logic [WIDTH-1:0] ram_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  dbg_req, dbg_we, dbg_addr, dbg_wd,
    input  ram_rd,
    output cpu_rd, cpu_stall,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_we, ram_addr, ram_wd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    output dbg_req, dbg_we, dbg_addr, dbg_wd,
    output ram_rd,
    input  cpu_rd, cpu_stall,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_we, ram_addr, ram_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the CPU MEM stage and the serial debugger, with starvation limit.
// Debug arbitration is present only when DMEM_ARB_DEBUG_EN is defined; otherwise a CPU passthrough.
module dmem_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          nreset,
  dmem_arbiter_if.slave bus
);

  assign bus.cpu_rd = bus.ram_rd;

`ifdef DMEM_ARB_DEBUG_EN
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(STARVE_LIM - 1);

  typedef enum logic {S_CPU, S_DBG} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             rvalid_q;
  logic [WIDTH-1:0] rdata_q;
  logic             dbg_rd_c;

  // A granted debug read captures the RAM's async data at the closing edge
  assign dbg_rd_c = bus.dbg_gnt & ~bus.dbg_we;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= S_CPU;
      wait_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rvalid_q <= dbg_rd_c;
      if (dbg_rd_c) rdata_q <= bus.ram_rd;
    end
  end

  // Next state, starvation counter and RAM port steering
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    bus.ram_we    = bus.cpu_req & bus.cpu_we;
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wd    = bus.cpu_wd;
    bus.cpu_stall = 1'b0;
    bus.dbg_gnt   = 1'b0;
    case (state_q)
      S_CPU: begin
        if (!bus.dbg_req) begin
          wait_d = '0;
        end else if (!bus.cpu_req || (wait_q == WAIT_MAX)) begin
          state_d = S_DBG;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DBG: begin
        bus.ram_addr  = bus.dbg_addr;
        bus.ram_wd    = bus.dbg_wd;
        bus.ram_we    = bus.dbg_req & bus.dbg_we;
        bus.dbg_gnt   = bus.dbg_req;
        bus.cpu_stall = bus.cpu_req;
        state_d       = S_CPU;
        wait_d        = '0;
      end
      default: begin
        state_d = S_CPU;
        wait_d  = '0;
      end
    endcase
    // Reset aborts any RAM write in flight, including a debug write
    if (!nreset) bus.ram_we = 1'b0;
  end

  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;
`else
  logic unused_dbg;

  assign bus.ram_we     = nreset & bus.cpu_req & bus.cpu_we;
  assign bus.ram_addr   = bus.cpu_addr;
  assign bus.ram_wd     = bus.cpu_wd;
  assign bus.cpu_stall  = 1'b0;
  assign bus.dbg_gnt    = 1'b0;
  assign bus.dbg_rvalid = 1'b0;
  assign bus.dbg_rdata  = WIDTH'(0);

  // Debug inputs and the starvation limit have no function in this build
  assign unused_dbg = &{1'b0, clk, bus.dbg_req, bus.dbg_we, bus.dbg_addr, bus.dbg_wd,
                        4'(STARVE_LIM)};
`endif

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter STARVE_LIM, default 4, the number of contended cycles before the debug port is forced a grant; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nreset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cpu_req  input  1  MEM-stage access request.
REQ-006 SHALL have port cpu_we  input  1  MEM-stage write enable; 0 means read.
REQ-007 SHALL have port cpu_addr  input  WIDTH  MEM-stage address.
REQ-008 SHALL have port cpu_wd  input  WIDTH  MEM-stage write data.
REQ-009 SHALL have port cpu_rd  output  WIDTH  read data; equals ram_rd combinationally.
REQ-010 SHALL have port cpu_stall  output  1  holds the fetch, register, EX and MEM pipeline registers.
REQ-011 SHALL have port dbg_req  input  1  serial-debugger access request; held until dbg_gnt.
REQ-012 SHALL have ports dbg_we  input  1, dbg_addr  input  WIDTH and dbg_wd  input  WIDTH  debug access.
REQ-013 SHALL have port dbg_gnt  output  1  debug access performed this cycle.
REQ-014 SHALL have ports dbg_rvalid  output  1 and dbg_rdata  output  WIDTH  registered debug read response.
REQ-015 SHALL have ports ram_we  output  1, ram_addr  output  WIDTH and ram_wd  output  WIDTH  to the data RAM; ram_rd  input  WIDTH  is the RAM's asynchronous read data.

Function
REQ-016 SHALL implement a two-state FSM: S_CPU (RAM owned by the CPU) and S_DBG (one debug access cycle).
REQ-017 In S_CPU: ram_* = cpu_*, with ram_we = cpu_req & cpu_we; cpu_stall=0; dbg_gnt=0.
REQ-018 In S_DBG: ram_addr/ram_wd = dbg_*; ram_we = dbg_req & dbg_we; dbg_gnt = dbg_req; cpu_stall = cpu_req.
REQ-019 S_CPU -> S_DBG at the next edge when dbg_req & (~cpu_req | wait_cnt == STARVE_LIM-1); otherwise the FSM stays in S_CPU.
REQ-020 S_DBG -> S_CPU unconditionally after one cycle; back-to-back debug grants are therefore impossible.
REQ-021 wait_cnt (4 bits) SHALL increment in S_CPU when dbg_req & cpu_req, saturate at STARVE_LIM-1, and clear on entry to S_DBG or when dbg_req=0.
REQ-022 On a dbg_gnt cycle with dbg_we=0, dbg_rdata SHALL latch ram_rd at the closing edge and dbg_rvalid SHALL pulse high for exactly the following cycle; otherwise dbg_rvalid=0 and dbg_rdata holds.
REQ-023 If dbg_req drops in S_DBG, that cycle SHALL be idle: no write, no dbg_rvalid, and cpu_stall still follows cpu_req.
REQ-024 A CPU request stalled in S_DBG SHALL complete in the following S_CPU cycle and SHALL observe any debug write made in the S_DBG cycle.
REQ-025 Latency: an uncontended debug access is granted 1 cycle after dbg_req rises, and read data is valid 2 cycles after dbg_req rises; under continuous cpu_req, the grant occurs STARVE_LIM cycles after dbg_req rises.

Reset
REQ-026 While nreset=0 at a rising edge: state=S_CPU, wait_cnt=0, dbg_rvalid=0, dbg_rdata=0.
REQ-027 ram_we SHALL be forced to 0 in any cycle where nreset=0, aborting an in-flight S_DBG access without an rvalid.
REQ-028 Outputs after reset: cpu_stall=0, dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0.

Configuration
REQ-029 Macro DMEM_ARB_DEBUG_EN defined: full arbitration as specified above.
REQ-030 Macro DMEM_ARB_DEBUG_EN undefined: dbg_* inputs are ignored; the FSM stays in S_CPU; dbg_gnt, dbg_rvalid and dbg_rdata are constant 0; cpu_stall is constant 0; ram_* = cpu_*.

Verification
REQ-031 Reset during S_DBG with dbg_we=1 -> ram_we=0, dbg_rvalid stays 0, and the next state is S_CPU.
REQ-032 Idle CPU; debug read of addr 0x10 with RAM[0x10]=0xDEADBEEF -> dbg_gnt at cycle 1, dbg_rvalid=1 with dbg_rdata=0xDEADBEEF at cycle 2, cpu_stall=0 throughout.
REQ-033 Continuous cpu_req; dbg_req rises at cycle 0 with STARVE_LIM=4 -> dbg_gnt at cycle 4 with cpu_stall=1 only in cycle 4, and no further grant in cycle 5.
REQ-034 Debug write 0x5A5A5A5A to 0x20 while the CPU reads 0x20 -> the CPU is stalled one cycle, then cpu_rd=0x5A5A5A5A.
REQ-035 dbg_req dropped in the S_DBG cycle -> ram_we=0, dbg_gnt=0, no dbg_rvalid.
REQ-036 Build without DMEM_ARB_DEBUG_EN and hold dbg_req=1 -> dbg_gnt never asserts, and CPU reads and writes pass through unaltered.
